// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared definitions for the MEM stage.
//   - MEMOP_* codes carried from EX
//   - SIZE_* codes on the data bus
//   - mem-stage FSM state type
//   - small memop decode helpers, used by the stage and the aligner
package mycpu_pkg;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LBU  = 4'd2;
    localparam logic [3:0] MEMOP_LH   = 4'd3;
    localparam logic [3:0] MEMOP_LHU  = 4'd4;
    localparam logic [3:0] MEMOP_LW   = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        StEmpty,
        StReq,
        StWait,
        StDone
    } mem_state_e;

    // Codes 9..15 fall through as NONE.
    function automatic logic memop_is_load(input logic [3:0] memop);
        return (memop >= MEMOP_LB) && (memop <= MEMOP_LW);
    endfunction

    function automatic logic memop_is_store(input logic [3:0] memop);
        return (memop >= MEMOP_SB) && (memop <= MEMOP_SW);
    endfunction

    function automatic logic [1:0] memop_size(input logic [3:0] memop);
        logic [1:0] size;
        case (memop)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: size = SIZE_BYTE;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: size = SIZE_HALF;
            default:                       size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic memop_misaligned(input logic [3:0] memop, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (memop_is_load(memop) || memop_is_store(memop)) begin
            case (memop_size(memop))
                SIZE_HALF: mis = addr_lo[0];
                SIZE_WORD: mis = (addr_lo != 2'b00);
                default:   mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mycpu_mem_align.sv
// mycpu_mem_align: combinational byte-lane steering for the MEM stage.
// Ports:
//   i_addr_lo     low address bits selecting the byte lane
//   i_memop       memop code
//   i_store_data  rt value for stores
//   i_rdata       full-word read data from the bus
//   o_is_load     memop is a load
//   o_is_store    memop is a store
//   o_misaligned  access violates natural alignment
//   o_size        bus size code
//   o_wstrb       byte write strobes (zero for non-stores)
//   o_wdata       lane-replicated store data
//   o_load_data   extended load result
module mycpu_mem_align
    import mycpu_pkg::*;
#(
    parameter int unsigned MEMOP_W = 4
) (
    input  logic [1:0]         i_addr_lo,
    input  logic [MEMOP_W-1:0] i_memop,
    input  logic [31:0]        i_store_data,
    input  logic [31:0]        i_rdata,
    output logic               o_is_load,
    output logic               o_is_store,
    output logic               o_misaligned,
    output logic [1:0]         o_size,
    output logic [3:0]         o_wstrb,
    output logic [31:0]        o_wdata,
    output logic [31:0]        o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_is_load    = memop_is_load(i_memop);
        o_is_store   = memop_is_store(i_memop);
        o_misaligned = memop_misaligned(i_memop, i_addr_lo);
        o_size       = memop_size(i_memop);
    end

    // Store side: replicate data across lanes; strobes pick the live lanes.
    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_store_data;
        case (i_memop)
            MEMOP_SB: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            MEMOP_SH: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            MEMOP_SW: begin
                o_wstrb = 4'b1111;
                o_wdata = i_store_data;
            end
            default: begin
                o_wstrb = 4'b0000;
                o_wdata = i_store_data;
            end
        endcase
    end

    // Load side: bus returns the whole word, so pick the lane by address.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_memop)
            MEMOP_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            MEMOP_LBU: o_load_data = {24'b0, w_byte};
            MEMOP_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            MEMOP_LHU: o_load_data = {16'b0, w_half};
            default:   o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mycpu_mem_stage.sv
// mycpu_mem_stage: memory-access pipeline stage between EX and WB.
// Captures one op from EX, issues it on a req/addr_ok/data_ok data bus,
// aligns and extends load data, and holds a single result for WB.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_ex_valid / o_mem_allowin     EX -> MEM handshake
//   i_ex_result, i_ex_store_data   address or pass-through value, store data
//   i_ex_memop, i_ex_dest, i_ex_wen
//   o_data_*                       request side of the data bus
//   i_data_addr_ok, i_data_rdata, i_data_data_ok   response side of the bus
//   i_wb_allowin / o_mem_valid     MEM -> WB handshake
//   o_mem_result, o_mem_dest, o_mem_wen, o_mem_adel, o_mem_ades  WB payload
module mycpu_mem_stage
    import mycpu_pkg::*;
#(
    parameter int unsigned DEST_W  = 5,
    parameter int unsigned MEMOP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ex_valid,
    output logic               o_mem_allowin,
    input  logic [31:0]        i_ex_result,
    input  logic [31:0]        i_ex_store_data,
    input  logic [MEMOP_W-1:0] i_ex_memop,
    input  logic [DEST_W-1:0]  i_ex_dest,
    input  logic               i_ex_wen,
    output logic               o_data_req,
    output logic               o_data_wr,
    output logic [1:0]         o_data_size,
    output logic [31:0]        o_data_addr,
    output logic [3:0]         o_data_wstrb,
    output logic [31:0]        o_data_wdata,
    input  logic               i_data_addr_ok,
    input  logic [31:0]        i_data_rdata,
    input  logic               i_data_data_ok,
    input  logic               i_wb_allowin,
    output logic               o_mem_valid,
    output logic [31:0]        o_mem_result,
    output logic [DEST_W-1:0]  o_mem_dest,
    output logic               o_mem_wen,
    output logic               o_mem_adel,
    output logic               o_mem_ades
);

    mem_state_e         r_state;
    mem_state_e         w_state_d;
    logic [31:0]        r_addr;
    logic [MEMOP_W-1:0] r_memop;
    logic [31:0]        r_store_data;
    logic [31:0]        r_result;
    logic [DEST_W-1:0]  r_dest;
    logic               r_wen;
    logic               r_adel;
    logic               r_ades;

    logic        w_capture;
    logic        w_ex_is_load;
    logic        w_ex_is_store;
    logic        w_ex_mis;
    logic        w_data_done;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    // Bus-side steering works from the captured op so the request stays stable.
    mycpu_mem_align #(
        .MEMOP_W (MEMOP_W)
    ) u_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_memop      (r_memop),
        .i_store_data (r_store_data),
        .i_rdata      (i_data_rdata),
        .o_is_load    (w_is_load),
        .o_is_store   (w_is_store),
        .o_misaligned (w_misaligned),
        .o_size       (w_size),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    // Capture-time classification decides between issuing and skipping the bus.
    always_comb begin
        w_ex_is_load  = memop_is_load(i_ex_memop);
        w_ex_is_store = memop_is_store(i_ex_memop);
        w_ex_mis      = memop_misaligned(i_ex_memop, i_ex_result[1:0]);
    end

    always_comb begin
        o_mem_allowin = (r_state == StEmpty) || ((r_state == StDone) && i_wb_allowin);
        w_capture     = i_ex_valid && o_mem_allowin;
        w_data_done   = ((r_state == StReq) && i_data_addr_ok && i_data_data_ok) ||
                        ((r_state == StWait) && i_data_data_ok);
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StEmpty, StDone: begin
                if (w_capture) begin
                    if ((w_ex_is_load || w_ex_is_store) && !w_ex_mis) begin
                        w_state_d = StReq;
                    end else begin
                        w_state_d = StDone;
                    end
                end else if ((r_state == StDone) && i_wb_allowin) begin
                    w_state_d = StEmpty;
                end
            end
            StReq: begin
                if (i_data_addr_ok) begin
                    w_state_d = i_data_data_ok ? StDone : StWait;
                end
            end
            StWait: begin
                if (i_data_data_ok) begin
                    w_state_d = StDone;
                end
            end
            default: w_state_d = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StEmpty;
            r_addr       <= '0;
            r_memop      <= '0;
            r_store_data <= '0;
            r_result     <= '0;
            r_dest       <= '0;
            r_wen        <= 1'b0;
            r_adel       <= 1'b0;
            r_ades       <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_capture) begin
                r_addr       <= i_ex_result;
                r_memop      <= i_ex_memop;
                r_store_data <= i_ex_store_data;
                // Pass-through value, store address or faulting address.
                r_result     <= i_ex_result;
                r_dest       <= i_ex_dest;
                r_wen        <= i_ex_wen && !w_ex_mis;
                r_adel       <= w_ex_mis && w_ex_is_load;
                r_ades       <= w_ex_mis && w_ex_is_store;
            end else if (w_data_done && w_is_load) begin
                r_result <= w_load_data;
            end
        end
    end

    // Misaligned ops never reach StReq; the gate only guards against corruption.
    always_comb begin
        o_data_req   = (r_state == StReq) && !w_misaligned;
        o_data_wr    = w_is_store;
        o_data_size  = w_size;
        o_data_addr  = r_addr;
        o_data_wstrb = w_wstrb;
        o_data_wdata = w_wdata;
        o_mem_valid  = (r_state == StDone);
        o_mem_result = r_result;
        o_mem_dest   = r_dest;
        o_mem_wen    = r_wen;
        o_mem_adel   = r_adel;
        o_mem_ades   = r_ades;
    end

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// Directed bench for mycpu_mem_stage with hand-computed expectations.
module tb_mycpu_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        mem_allowin;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_wen;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        wb_allowin;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic [4:0]  mem_dest;
    logic        mem_wen;
    logic        mem_adel;
    logic        mem_ades;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mycpu_mem_stage #(
        .DEST_W  (5),
        .MEMOP_W (4)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_ex_valid      (ex_valid),
        .o_mem_allowin   (mem_allowin),
        .i_ex_result     (ex_result),
        .i_ex_store_data (ex_store_data),
        .i_ex_memop      (ex_memop),
        .i_ex_dest       (ex_dest),
        .i_ex_wen        (ex_wen),
        .o_data_req      (data_req),
        .o_data_wr       (data_wr),
        .o_data_size     (data_size),
        .o_data_addr     (data_addr),
        .o_data_wstrb    (data_wstrb),
        .o_data_wdata    (data_wdata),
        .i_data_addr_ok  (data_addr_ok),
        .i_data_rdata    (data_rdata),
        .i_data_data_ok  (data_data_ok),
        .i_wb_allowin    (wb_allowin),
        .o_mem_valid     (mem_valid),
        .o_mem_result    (mem_result),
        .o_mem_dest      (mem_dest),
        .o_mem_wen       (mem_wen),
        .o_mem_adel      (mem_adel),
        .o_mem_ades      (mem_ades)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] sd,
                            input logic [4:0] d, input logic w);
        ex_valid      = 1'b1;
        ex_memop      = m;
        ex_result     = a;
        ex_store_data = sd;
        ex_dest       = d;
        ex_wen        = w;
    endtask

    // Load whose addr_ok and data_ok both arrive in the first request cycle.
    task automatic quick_load(input string tag, input logic [3:0] m, input logic [31:0] a,
                              input logic [31:0] rd, input logic [31:0] exp);
        drive_op(m, a, 32'h0, 5'd2, 1'b1);
        step();
        ex_valid = 1'b0;
        check({tag, "_req"}, 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = rd;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        check({tag, "_valid"}, 32'(mem_valid), 32'd1);
        check({tag, "_result"}, mem_result, exp);
        step();
    endtask

    // Op that completes without the bus: DONE after one edge.
    task automatic quick_nobus(input string tag, input logic [3:0] m, input logic [31:0] a,
                               input logic [31:0] exp_result, input logic exp_adel,
                               input logic exp_ades, input logic exp_wen);
        drive_op(m, a, 32'h0, 5'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        check({tag, "_valid"}, 32'(mem_valid), 32'd1);
        check({tag, "_req"}, 32'(data_req), 32'd0);
        check({tag, "_result"}, mem_result, exp_result);
        check({tag, "_adel"}, 32'(mem_adel), 32'(exp_adel));
        check({tag, "_ades"}, 32'(mem_ades), 32'(exp_ades));
        check({tag, "_wen"}, 32'(mem_wen), 32'(exp_wen));
        step();
    endtask

    initial begin
        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_result     = '0;
        ex_store_data = '0;
        ex_memop      = '0;
        ex_dest       = '0;
        ex_wen        = 1'b0;
        data_addr_ok  = 1'b0;
        data_rdata    = '0;
        data_data_ok  = 1'b0;
        wb_allowin    = 1'b1;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_adel", 32'(mem_adel), 32'd0);
        check("rst_ades", 32'(mem_ades), 32'd0);
        check("rst_result", mem_result, 32'h0);
        check("rst_dest", 32'(mem_dest), 32'd0);
        check("rst_allowin", 32'(mem_allowin), 32'd1);
        reset = 1'b0;
        step();

        // NONE pass-through, one-cycle latency
        drive_op(4'd0, 32'h1234_5678, 32'h0, 5'd3, 1'b1);
        check("none_allowin", 32'(mem_allowin), 32'd1);
        step();
        ex_valid = 1'b0;
        check("none_valid", 32'(mem_valid), 32'd1);
        check("none_result", mem_result, 32'h1234_5678);
        check("none_dest", 32'(mem_dest), 32'd3);
        check("none_wen", 32'(mem_wen), 32'd1);
        check("none_req", 32'(data_req), 32'd0);
        step();
        check("none_drain", 32'(mem_valid), 32'd0);

        // data_ok while EMPTY is ignored
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("stray_ok_valid", 32'(mem_valid), 32'd0);

        // LB at 0x103: addr_ok on third request cycle, data_ok third WAIT cycle
        drive_op(4'd1, 32'h0000_0103, 32'h0, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lb_req", 32'(data_req), 32'd1);
            check("lb_addr", data_addr, 32'h0000_0103);
            check("lb_size", 32'(data_size), 32'd0);
            check("lb_wr", 32'(data_wr), 32'd0);
            data_addr_ok = (i == 2);
            step();
        end
        data_addr_ok = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("lb_wait_req", 32'(data_req), 32'd0);
            check("lb_wait_valid", 32'(mem_valid), 32'd0);
            data_data_ok = (j == 2);
            data_rdata   = 32'h80FF_0011;
            step();
        end
        data_data_ok = 1'b0;
        check("lb_valid", 32'(mem_valid), 32'd1);
        check("lb_result", mem_result, 32'hFFFF_FF80);
        check("lb_dest", 32'(mem_dest), 32'd5);
        check("lb_wen", 32'(mem_wen), 32'd1);
        step();

        // Load extension / lane variants
        quick_load("lbu", 4'd2, 32'h0000_0103, 32'h80FF_0011, 32'h0000_0080);
        quick_load("lb0", 4'd1, 32'h0000_0100, 32'h80FF_0011, 32'h0000_0011);
        quick_load("lh2", 4'd3, 32'h0000_0102, 32'h80FF_0011, 32'hFFFF_80FF);
        quick_load("lhu0", 4'd4, 32'h0000_0100, 32'h80FF_8011, 32'h0000_8011);
        quick_load("lw", 4'd5, 32'h0000_0104, 32'h80FF_0011, 32'h80FF_0011);

        // SH at 0x202, addr_ok and data_ok together
        drive_op(4'd7, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        check("sh_req", 32'(data_req), 32'd1);
        check("sh_wr", 32'(data_wr), 32'd1);
        check("sh_size", 32'(data_size), 32'd1);
        check("sh_addr", data_addr, 32'h0000_0202);
        check("sh_wstrb", 32'(data_wstrb), 32'hC);
        check("sh_wdata", data_wdata, 32'hBEEF_BEEF);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        check("sh_valid", 32'(mem_valid), 32'd1);
        check("sh_result", mem_result, 32'h0000_0202);
        check("sh_wen", 32'(mem_wen), 32'd0);
        step();

        // SB at 0x201 waits for data_ok after addr_ok
        drive_op(4'd6, 32'h0000_0201, 32'h1234_56EF, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        check("sb_wstrb", 32'(data_wstrb), 32'h2);
        check("sb_wdata", data_wdata, 32'hEFEF_EFEF);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("sb_wait_valid", 32'(mem_valid), 32'd0);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("sb_valid", 32'(mem_valid), 32'd1);
        check("sb_result", mem_result, 32'h0000_0201);
        step();

        // Misaligned and unused codes skip the bus
        quick_nobus("lw_mis", 4'd5, 32'h0000_0106, 32'h0000_0106, 1'b1, 1'b0, 1'b0);
        quick_nobus("sw_mis", 4'd8, 32'h0000_0101, 32'h0000_0101, 1'b0, 1'b1, 1'b0);
        quick_nobus("lh_mis", 4'd3, 32'h0000_0103, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
        quick_nobus("code12", 4'd12, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0, 1'b1);

        // Backpressure in DONE, then back-to-back acceptance
        wb_allowin = 1'b0;
        drive_op(4'd0, 32'hAAAA_5555, 32'h0, 5'd7, 1'b1);
        step();
        ex_valid = 1'b0;
        check("bp_valid", 32'(mem_valid), 32'd1);
        check("bp_allowin", 32'(mem_allowin), 32'd0);
        step();
        drive_op(4'd0, 32'hCAFE_0001, 32'h0, 5'd9, 1'b1);
        step();
        check("bp_hold_result", mem_result, 32'hAAAA_5555);
        check("bp_hold_dest", 32'(mem_dest), 32'd7);
        check("bp_hold_valid", 32'(mem_valid), 32'd1);
        wb_allowin = 1'b1;
        #1;
        check("b2b_allowin", 32'(mem_allowin), 32'd1);
        step();
        ex_valid = 1'b0;
        check("b2b_valid", 32'(mem_valid), 32'd1);
        check("b2b_result", mem_result, 32'hCAFE_0001);
        check("b2b_dest", 32'(mem_dest), 32'd9);
        step();
        check("b2b_drain", 32'(mem_valid), 32'd0);

        // Reset while in WAIT
        drive_op(4'd5, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
        step();
        ex_valid     = 1'b0;
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("wait_req", 32'(data_req), 32'd0);
        check("wait_allowin", 32'(mem_allowin), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_valid", 32'(mem_valid), 32'd0);
        check("rstw_req", 32'(data_req), 32'd0);
        check("rstw_allowin", 32'(mem_allowin), 32'd1);

        // Stage still works after the mid-transaction reset
        quick_nobus("post_rst", 4'd0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
